// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive control unit.
// Holds the RCU state encoding, PID codes and the PID classification helpers.
package usb_rx_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SYNC_WAIT,
    SYNC_CHK,
    PID_WAIT,
    PID_CHK,
    DATA_WAIT,
    DATA_STORE,
    EOP_WAIT,
    DONE,
    EOP_HOLD,
    ERR_WAIT_EOP,
    ERR_IDLE
  } rcu_state_t;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h80;

  function automatic logic pid_is_handshake(input logic [3:0] pid);
    return (pid == PID_ACK) || (pid == PID_NAK) || (pid == PID_STALL);
  endfunction

  function automatic logic pid_is_defined(input logic [3:0] pid);
    return pid_is_handshake(pid) ||
           (pid == PID_OUT)   || (pid == PID_IN)    || (pid == PID_SOF) ||
           (pid == PID_SETUP) || (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear and programmable wrap value.
// Reaching rollover_val wraps the count back to zero on the next enable.
module flex_counter #(
  parameter int NUM_CNT_BITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  logic [NUM_CNT_BITS-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_enable) begin
      r_count <= (r_count == rollover_val) ? '0 : r_count + 1'b1;
    end
  end

  assign count_out = r_count;

endmodule

// File: rtl/usb_rx_rcu.sv
// USB RX receiver control unit: SYNC/PID validation, payload steering into
// the RX FIFO, timer sequencing and sticky protocol error reporting.
module usb_rx_rcu
  import usb_rx_pkg::*;
#(
  parameter int         MAX_BYTES = 64,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  input  logic       fifo_full,
  output logic       rcving,
  output logic       enable_timer,
  output logic       timer_clear,
  output logic       w_enable,
  output logic [3:0] rx_pid,
  output logic       rx_done,
  output logic       r_error
);

  localparam int CW = $clog2(MAX_BYTES + 1);

  rcu_state_t       r_state;
  rcu_state_t       w_next_state;
  logic [CW-1:0]    r_byte_cnt;
  logic [2:0]       w_bit_cnt;
  logic             w_pid_ok;
  logic             w_store_ok;
  logic             w_start;

  // Bit counter follows the timer: it restarts whenever the timer is held clear.
  flex_counter #(.NUM_CNT_BITS(3)) u_bit_cnt (
    .clk          (clk),
    .rst          (rst),
    .clear        (byte_received | timer_clear),
    .count_enable (shift_enable),
    .rollover_val (3'd7),
    .count_out    (w_bit_cnt)
  );

  assign w_pid_ok   = (rcv_data[7:4] == ~rcv_data[3:0]) && pid_is_defined(rcv_data[3:0]);
  assign w_store_ok = !fifo_full && (r_byte_cnt != CW'(MAX_BYTES));
  assign w_start    = d_edge && !eop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:         if (w_start) w_next_state = SYNC_WAIT;
      SYNC_WAIT:    if (byte_received) w_next_state = SYNC_CHK;
                    else if (eop) w_next_state = ERR_IDLE;
      SYNC_CHK:     w_next_state = (rcv_data == SYNC_BYTE) ? PID_WAIT : ERR_WAIT_EOP;
      PID_WAIT:     if (byte_received) w_next_state = PID_CHK;
                    else if (eop) w_next_state = ERR_IDLE;
      PID_CHK:      if (!w_pid_ok) w_next_state = ERR_WAIT_EOP;
                    else if (pid_is_handshake(rcv_data[3:0])) w_next_state = EOP_WAIT;
                    else w_next_state = DATA_WAIT;
      DATA_WAIT:    if (byte_received) w_next_state = DATA_STORE;
                    else if (eop) w_next_state = (w_bit_cnt == 3'd0) ? DONE : ERR_IDLE;
      DATA_STORE:   if (!w_store_ok) w_next_state = ERR_WAIT_EOP;
                    else w_next_state = eop ? DONE : DATA_WAIT;
      EOP_WAIT:     if (eop) w_next_state = DONE;
                    else if (byte_received) w_next_state = ERR_WAIT_EOP;
      DONE:         w_next_state = eop ? EOP_HOLD : IDLE;
      EOP_HOLD:     if (!eop) w_next_state = IDLE;
      ERR_WAIT_EOP: if (eop) w_next_state = ERR_IDLE;
      ERR_IDLE:     if (w_start) w_next_state = SYNC_WAIT;
      default:      w_next_state = IDLE;
    endcase
  end

  assign enable_timer = (r_state inside {SYNC_WAIT, SYNC_CHK, PID_WAIT, PID_CHK,
                                         DATA_WAIT, DATA_STORE, EOP_WAIT, ERR_WAIT_EOP});
  assign rcving       = enable_timer;
  assign timer_clear  = !enable_timer;
  assign rx_done      = (r_state == DONE);
  // A rejected store (full FIFO or payload limit) never pulses the write strobe.
  assign w_enable     = (r_state == DATA_STORE) && w_store_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt <= '0;
      rx_pid     <= 4'h0;
      r_error    <= 1'b0;
    end else begin
      if (w_next_state == SYNC_WAIT && r_state != SYNC_WAIT) begin
        r_byte_cnt <= '0;
      end else if (w_enable) begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end
      if (r_state == PID_CHK && w_pid_ok) begin
        rx_pid <= rcv_data[3:0];
      end
      if ((r_state == IDLE || r_state == ERR_IDLE) && w_next_state == SYNC_WAIT) begin
        r_error <= 1'b0;
      end else if (w_next_state == ERR_WAIT_EOP || w_next_state == ERR_IDLE) begin
        r_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_rcu.sv
// Directed bench for usb_rx_rcu: one task per scenario with inline checks.
// A second instance with a two-byte payload limit covers the overflow case.
module tb_usb_rx_rcu;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d_edge = 1'b0, eop = 1'b0, shift_enable = 1'b0, byte_received = 1'b0;
  logic       fifo_full = 1'b0;
  logic [7:0] rcv_data = 8'h00;

  logic       rcving, enable_timer, timer_clear, w_enable, rx_done, r_error;
  logic [3:0] rx_pid;
  logic       b_rcving, b_enable_timer, b_timer_clear, b_w_enable, b_rx_done, b_r_error;
  logic [3:0] b_rx_pid;

  int errors = 0;
  int checks = 0;
  logic [7:0] wr_q[$];
  int done_cnt = 0;
  int b_wr_cnt = 0;
  int b_done_cnt = 0;

  usb_rx_rcu dut (
    .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop), .shift_enable(shift_enable),
    .byte_received(byte_received), .rcv_data(rcv_data), .fifo_full(fifo_full),
    .rcving(rcving), .enable_timer(enable_timer), .timer_clear(timer_clear),
    .w_enable(w_enable), .rx_pid(rx_pid), .rx_done(rx_done), .r_error(r_error)
  );

  usb_rx_rcu #(.MAX_BYTES(2)) dut2 (
    .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop), .shift_enable(shift_enable),
    .byte_received(byte_received), .rcv_data(rcv_data), .fifo_full(fifo_full),
    .rcving(b_rcving), .enable_timer(b_enable_timer), .timer_clear(b_timer_clear),
    .w_enable(b_w_enable), .rx_pid(b_rx_pid), .rx_done(b_rx_done), .r_error(b_r_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (w_enable) wr_q.push_back(rcv_data);
    if (rx_done) done_cnt++;
    if (b_w_enable) b_wr_cnt++;
    if (b_rx_done) b_done_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    wr_q.delete();
    done_cnt = 0;
    b_wr_cnt = 0;
    b_done_cnt = 0;
  endtask

  task automatic start_pkt();
    d_edge = 1'b1;
    cyc(1);
    d_edge = 1'b0;
  endtask

  // Eight bit strobes, a byte strobe, then one cycle for the check/store state.
  task automatic send_byte(input logic [7:0] b);
    rcv_data = b;
    shift_enable = 1'b1;
    cyc(8);
    shift_enable = 1'b0;
    byte_received = 1'b1;
    cyc(1);
    byte_received = 1'b0;
    cyc(1);
  endtask

  task automatic send_eop();
    eop = 1'b1;
    cyc(2);
    eop = 1'b0;
    cyc(2);
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    checks++; if (timer_clear !== 1'b1) begin errors++; $display("FAIL reset_timer_clear: got %b expected 1", timer_clear); end
    checks++; if ({rcving, enable_timer, w_enable, rx_done, r_error} !== 5'b0) begin errors++; $display("FAIL reset_outputs: got %b expected 00000", {rcving, enable_timer, w_enable, rx_done, r_error}); end
    checks++; if (rx_pid !== 4'h0) begin errors++; $display("FAIL reset_pid: got %h expected 0", rx_pid); end
    cyc(2);
    rst = 1'b0;
    cyc(1);
    start_pkt();
    send_byte(8'h80);
    checks++; if (rcving !== 1'b1) begin errors++; $display("FAIL midpkt_rcving: got %b expected 1", rcving); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({rcving, timer_clear} !== 2'b01) begin errors++; $display("FAIL async_reset: got %b expected 01", {rcving, timer_clear}); end
    cyc(1);
    rst = 1'b0;
    cyc(1);
    $display("reset: async reset checked");
  endtask

  task automatic test_data_packet();
    clear_counts();
    start_pkt();
    checks++; if ({rcving, enable_timer, timer_clear} !== 3'b110) begin errors++; $display("FAIL sync_wait_outputs: got %b expected 110", {rcving, enable_timer, timer_clear}); end
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_eop();
    checks++; if (wr_q.size() !== 3) begin errors++; $display("FAIL data_wr_count: got %0d expected 3", wr_q.size()); end
    if (wr_q.size() == 3) begin
      checks++; if (wr_q[0] !== 8'h11) begin errors++; $display("FAIL data_wr0: got %h expected 11", wr_q[0]); end
      checks++; if (wr_q[1] !== 8'h22) begin errors++; $display("FAIL data_wr1: got %h expected 22", wr_q[1]); end
      checks++; if (wr_q[2] !== 8'h33) begin errors++; $display("FAIL data_wr2: got %h expected 33", wr_q[2]); end
    end
    checks++; if (rx_pid !== 4'h3) begin errors++; $display("FAIL data_pid: got %h expected 3", rx_pid); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL data_done: got %0d expected 1", done_cnt); end
    checks++; if (r_error !== 1'b0) begin errors++; $display("FAIL data_error: got %b expected 0", r_error); end
    checks++; if (timer_clear !== 1'b1) begin errors++; $display("FAIL data_idle_clear: got %b expected 1", timer_clear); end
    $display("pkt DATA0 11 22 33: writes=%0d done=%0d pid=%h", wr_q.size(), done_cnt, rx_pid);
  endtask

  task automatic test_handshake();
    clear_counts();
    start_pkt();
    send_byte(8'h80);
    send_byte(8'hD2);
    checks++; if (enable_timer !== 1'b1) begin errors++; $display("FAIL ack_eop_wait_timer: got %b expected 1", enable_timer); end
    send_eop();
    checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL ack_writes: got %0d expected 0", wr_q.size()); end
    checks++; if (rx_pid !== 4'h2) begin errors++; $display("FAIL ack_pid: got %h expected 2", rx_pid); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ack_done: got %0d expected 1", done_cnt); end
    checks++; if (r_error !== 1'b0) begin errors++; $display("FAIL ack_error: got %b expected 0", r_error); end
    $display("pkt ACK: done=%0d pid=%h", done_cnt, rx_pid);
  endtask

  task automatic test_bad_sync();
    clear_counts();
    start_pkt();
    send_byte(8'h81);
    checks++; if ({r_error, rcving} !== 2'b11) begin errors++; $display("FAIL badsync_err: got %b expected 11", {r_error, rcving}); end
    cyc(3);
    checks++; if ({r_error, rcving, enable_timer} !== 3'b111) begin errors++; $display("FAIL badsync_hold: got %b expected 111", {r_error, rcving, enable_timer}); end
    send_eop();
    checks++; if ({r_error, rcving, timer_clear} !== 3'b101) begin errors++; $display("FAIL badsync_erridle: got %b expected 101", {r_error, rcving, timer_clear}); end
    eop = 1'b1;
    d_edge = 1'b1;
    cyc(1);
    checks++; if ({r_error, rcving} !== 2'b10) begin errors++; $display("FAIL badsync_edge_in_eop: got %b expected 10", {r_error, rcving}); end
    eop = 1'b0;
    cyc(1);
    d_edge = 1'b0;
    checks++; if ({r_error, rcving} !== 2'b01) begin errors++; $display("FAIL badsync_restart: got %b expected 01", {r_error, rcving}); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL badsync_done: got %0d expected 0", done_cnt); end
    send_eop();
    $display("pkt SYNC 81: error flagged and cleared by next edge");
  endtask

  task automatic test_bad_pid();
    clear_counts();
    start_pkt();
    send_byte(8'h80);
    send_byte(8'hC4);
    send_byte(8'h55);
    checks++; if ({r_error, rcving} !== 2'b11) begin errors++; $display("FAIL badpid_err: got %b expected 11", {r_error, rcving}); end
    send_eop();
    checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL badpid_writes: got %0d expected 0", wr_q.size()); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL badpid_done: got %0d expected 0", done_cnt); end
    $display("pkt PID C4: writes=%0d error=%b", wr_q.size(), r_error);
  endtask

  task automatic test_truncated();
    clear_counts();
    start_pkt();
    send_byte(8'h80);
    send_byte(8'h4B);
    shift_enable = 1'b1;
    cyc(3);
    shift_enable = 1'b0;
    send_eop();
    checks++; if ({r_error, rcving, timer_clear} !== 3'b101) begin errors++; $display("FAIL trunc_state: got %b expected 101", {r_error, rcving, timer_clear}); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL trunc_done: got %0d expected 0", done_cnt); end
    checks++; if (rx_pid !== 4'hB) begin errors++; $display("FAIL trunc_pid: got %h expected B", rx_pid); end
    checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL trunc_writes: got %0d expected 0", wr_q.size()); end
    $display("pkt DATA1 truncated: error=%b done=%0d", r_error, done_cnt);
  endtask

  task automatic test_max_bytes();
    clear_counts();
    start_pkt();
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_eop();
    checks++; if (b_wr_cnt !== 2) begin errors++; $display("FAIL max_writes: got %0d expected 2", b_wr_cnt); end
    checks++; if (b_r_error !== 1'b1) begin errors++; $display("FAIL max_error: got %b expected 1", b_r_error); end
    checks++; if (b_done_cnt !== 0) begin errors++; $display("FAIL max_done: got %0d expected 0", b_done_cnt); end
    checks++; if (wr_q.size() !== 3) begin errors++; $display("FAIL max_big_writes: got %0d expected 3", wr_q.size()); end
    $display("pkt overflow MAX_BYTES=2: writes=%0d error=%b", b_wr_cnt, b_r_error);
  endtask

  task automatic test_fifo_full();
    clear_counts();
    fifo_full = 1'b1;
    start_pkt();
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(8'h11);
    checks++; if ({r_error, rcving} !== 2'b11) begin errors++; $display("FAIL full_err: got %b expected 11", {r_error, rcving}); end
    send_eop();
    fifo_full = 1'b0;
    checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL full_writes: got %0d expected 0", wr_q.size()); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL full_done: got %0d expected 0", done_cnt); end
    $display("pkt fifo_full: writes=%0d error=%b", wr_q.size(), r_error);
  endtask

  task automatic test_back_to_back();
    clear_counts();
    start_pkt();
    send_byte(8'h80);
    send_byte(8'h5A);
    send_eop();
    checks++; if (rx_pid !== 4'hA) begin errors++; $display("FAIL b2b_nak_pid: got %h expected A", rx_pid); end
    start_pkt();
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(8'hAA);
    send_eop();
    checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done: got %0d expected 2", done_cnt); end
    checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL b2b_writes: got %0d expected 1", wr_q.size()); end
    if (wr_q.size() == 1) begin
      checks++; if (wr_q[0] !== 8'hAA) begin errors++; $display("FAIL b2b_data: got %h expected AA", wr_q[0]); end
    end
    checks++; if ({rx_pid, r_error} !== 5'b0011_0) begin errors++; $display("FAIL b2b_pid_err: got %b expected 00110", {rx_pid, r_error}); end
    $display("pkt NAK then DATA0 AA: done=%0d writes=%0d", done_cnt, wr_q.size());
  endtask

  initial begin
    test_reset();
    test_data_packet();
    test_handshake();
    test_bad_sync();
    test_bad_pid();
    test_truncated();
    test_max_bytes();
    test_fifo_full();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_rx_rcu.md
Name: usb_rx_rcu

Overview:
Receiver control unit for the USB RX path. Sequences the bit/byte timer: enables it, clears it on EOP and error, and qualifies its byte strobes. Validates SYNC and PID, steers payload bytes into the RX FIFO, and flags protocol errors. Sits between the edge/EOP detectors and the timer/shift-register/FIFO.

Parameters:
MAX_BYTES, 64, payload bytes accepted per packet before overflow error
SYNC_BYTE, 8'h80, required first byte (LSB-first shift result)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
d_edge  in  1  line transition strobe from edge detector
eop  in  1  EOP level from EOP detector
shift_enable  in  1  timer bit-sample strobe
byte_received  in  1  timer byte-complete strobe (1 cycle)
rcv_data  in  8  shift-register byte, valid on byte_received
fifo_full  in  1  RX FIFO cannot accept a write
rcving  out  1  packet in progress
enable_timer  out  1  drives timer enable_timer
timer_clear  out  1  drives timer eop_detected (clears bit counter)
w_enable  out  1  one-cycle FIFO write strobe, data = rcv_data
rx_pid  out  4  latched PID of current/last packet
rx_done  out  1  one-cycle pulse on good packet end
r_error  out  1  sticky error flag

Behaviour:
- Reset: state IDLE; all outputs 0 except timer_clear=1; rx_pid=4'h0; byte_cnt=0, bit_cnt=0.
- All outputs are Moore, decoded from registered state; rx_pid and r_error are registers.
- bit_cnt (3b): +1 on shift_enable, wraps 7->0, cleared on byte_received and in IDLE. byte_cnt: cleared on SYNC_WAIT entry.
- IDLE: timer_clear=1. On d_edge & !eop -> SYNC_WAIT; r_error cleared on this transition.
- SYNC_WAIT: rcving=1, enable_timer=1. byte_received -> SYNC_CHK. eop (no byte) -> ERR_IDLE.
- SYNC_CHK (1 cycle): rcv_data==SYNC_BYTE -> PID_WAIT, else -> ERR_WAIT_EOP.
- PID_WAIT: byte_received -> PID_CHK; eop -> ERR_IDLE.
- PID_CHK (1 cycle): valid iff rcv_data[7:4]==~rcv_data[3:0] and rcv_data[3:0] is a defined PID. Invalid -> ERR_WAIT_EOP. Valid: rx_pid<=rcv_data[3:0]. Handshake (ACK/NAK/STALL) -> EOP_WAIT; others -> DATA_WAIT.
- DATA_WAIT: byte_received has priority over eop -> DATA_STORE. eop & bit_cnt==0 -> DONE. eop & bit_cnt!=0 -> ERR_IDLE (truncated byte).
- DATA_STORE (1 cycle):
  - fifo_full -> ERR_WAIT_EOP, no write.
  - byte_cnt==MAX_BYTES -> ERR_WAIT_EOP, no write.
  - Otherwise w_enable=1, byte_cnt+1, then DONE if eop else DATA_WAIT.
- EOP_WAIT: eop -> DONE; byte_received -> ERR_WAIT_EOP.
- DONE: rx_done=1 for exactly one cycle, timer_clear=1, rcving=0. Waits in EOP_HOLD while eop=1, then IDLE.
- ERR_WAIT_EOP: r_error<=1, rcving=1, enable_timer=1, w_enable never asserted. eop -> ERR_IDLE.
- ERR_IDLE: r_error held 1, timer_clear=1, rcving=0. d_edge & !eop -> SYNC_WAIT (clears r_error). d_edge while eop=1 is ignored.
- EOP_HOLD: timer_clear=1; !eop -> IDLE.
- enable_timer=1 only in SYNC_WAIT..EOP_WAIT and ERR_WAIT_EOP. timer_clear=1 whenever enable_timer=0.
- Reset mid-packet returns to IDLE within the reset assertion. No partial write is possible because w_enable is decoded from state.

Decomposition:
- usb_rx_pkg holds:
  - rcu_state_t enum: IDLE, SYNC_WAIT, SYNC_CHK, PID_WAIT, PID_CHK, DATA_WAIT, DATA_STORE, EOP_WAIT, DONE, EOP_HOLD, ERR_WAIT_EOP, ERR_IDLE.
  - PID constants: OUT=1, IN=9, SOF=5, SETUP=D, DATA0=3, DATA1=B, ACK=2, NAK=A, STALL=E.
  - SYNC_BYTE default.
- bit_cnt is one flex_counter instance (NUM_CNT_BITS=3, rollover 7), cleared by byte_received.
- byte_cnt is inline.

Test Plan:
- SYNC 80, PID C3 (DATA0), bytes 11 22 33, eop at bit_cnt 0 -> three w_enable pulses with 11, 22, 33; rx_pid=3; one rx_done; r_error=0.
- SYNC 80, PID D2 (ACK), eop -> no w_enable; rx_pid=2; rx_done pulse.
- SYNC 81 -> r_error=1 from SYNC_CHK+1; stays in ERR_WAIT_EOP until eop; next d_edge clears r_error.
- PID C4 (nibble check fails) -> ERR_WAIT_EOP, no writes, r_error=1.
- DATA1 packet with eop after 3 shift_enables mid-byte -> ERR_IDLE, r_error=1, no rx_done.
- MAX_BYTES=2 with 3 payload bytes -> two writes, third rejected, r_error=1. Separately: fifo_full high on first byte -> zero writes, r_error=1.
